// File: rtl/temp_pkg.sv
// rtl/temp_pkg.sv - shared temperature-path constants and logger state type
package temp_pkg;

  // ADC sample width, shared with temp_to_led and trojan
  localparam int DATA_W = 12;

  typedef enum logic [1:0] {
    DISCARD,
    ACCUM,
    WRITE
  } log_state_t;

endpackage

// File: rtl/min_max_tracker.sv
// rtl/min_max_tracker.sv - running minimum/maximum of a strobed sample stream
module min_max_tracker #(
  parameter int DATA_W = temp_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic [DATA_W-1:0] min,
  output logic [DATA_W-1:0] max
);

  // set once the first sample has been seen; until then min/max hold the reset zeros
  logic loaded;

  // first valid sample loads both extremes, later ones only widen the range
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loaded <= 1'b0;
      min    <= '0;
      max    <= '0;
    end else if (sample_valid) begin
      loaded <= 1'b1;
      if (!loaded || sample < min) min <= sample;
      if (!loaded || sample > max) max <= sample;
    end
  end

endmodule

// File: rtl/adc_avg_logger.sv
// rtl/adc_avg_logger.sv - windowed ADC averager writing into a RAM ring
module adc_avg_logger #(
  parameter int DATA_W  = temp_pkg::DATA_W,
  parameter int LOG2_N  = 3,
  parameter int ADDR_W  = 4,
  parameter int DISCARD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              avg_valid,
  output logic [DATA_W-1:0] avg_data,
  output logic [DATA_W-1:0] min_data,
  output logic [DATA_W-1:0] max_data,
  output logic              wrapped
);

  localparam int ACC_W = DATA_W + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam int DC_W  = $clog2(DISCARD + 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_N) - 1);

  temp_pkg::log_state_t state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DC_W-1:0]   dcnt_q, dcnt_d;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic              ring_full_q;
  logic              wren_q;
  logic              wrapped_q;
  logic [ACC_W-1:0]  sum;

  // the window never exceeds 2^LOG2_N full-scale samples, so ACC_W bits cannot overflow
  assign sum = acc_q + ACC_W'(adc_data);

  // next-state, settling-sample counting and window accumulation
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    avg_d   = avg_q;
    unique case (state_q)
      temp_pkg::DISCARD: begin
        if (!en) begin
          dcnt_d = '0;
        end else if (DISCARD == 0) begin
          state_d = temp_pkg::ACCUM;
        end else if (adc_valid) begin
          if (dcnt_q == DC_W'(DISCARD - 1)) begin
            dcnt_d  = '0;
            state_d = temp_pkg::ACCUM;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end
      temp_pkg::ACCUM: begin
        if (!en) begin
          state_d = temp_pkg::DISCARD;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (adc_valid) begin
          if (cnt_q == LAST_CNT) begin
            avg_d   = DATA_W'(sum >> LOG2_N);
            state_d = temp_pkg::WRITE;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      temp_pkg::WRITE: begin
        // a sample arriving during the write opens the next window
        if (!en) begin
          state_d = temp_pkg::DISCARD;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = temp_pkg::ACCUM;
          acc_d   = adc_valid ? ACC_W'(adc_data) : '0;
          cnt_d   = adc_valid ? CNT_W'(1) : '0;
        end
      end
      default: begin
        state_d = temp_pkg::DISCARD;
        acc_d   = '0;
        cnt_d   = '0;
        dcnt_d  = '0;
      end
    endcase
  end

  // FSM, accumulator and latched average
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= temp_pkg::DISCARD;
      acc_q   <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      avg_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      avg_q   <= avg_d;
    end
  end

  // write strobe, ring pointer and the sticky wrap flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wren_q      <= 1'b0;
      wr_ptr_q    <= '0;
      ring_full_q <= 1'b0;
      wrapped_q   <= 1'b0;
    end else begin
      wren_q <= (state_d == temp_pkg::WRITE);
      if (state_q == temp_pkg::WRITE) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (&wr_ptr_q) ring_full_q <= 1'b1;
      end
      // raised together with the strobe of the first write that reuses address 0
      if (state_d == temp_pkg::WRITE && ring_full_q && wr_ptr_q == '0) wrapped_q <= 1'b1;
    end
  end

  min_max_tracker #(.DATA_W(DATA_W)) u_min_max (
    .clk          (clk),
    .rst          (rst),
    .sample       (avg_q),
    .sample_valid (wren_q),
    .min          (min_data),
    .max          (max_data)
  );

  assign ram_wren  = wren_q;
  assign avg_valid = wren_q;
  assign ram_addr  = wr_ptr_q;
  assign ram_data  = avg_q;
  assign avg_data  = avg_q;
  assign wrapped   = wrapped_q;

endmodule
